fetch_unit: RTL and testbench

//  Instruction-fetch stage; feeds FetchData_IF into decode. Owns the PC,

---
 rtl/fetch_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/ready
// handshake to instruction memory and presents one registered word to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        AnyStall,
  input  logic        flush,
  input  logic        BranchTaken_EX,
  input  logic [31:0] BranchTgt_EX,
  input  logic        Jump_ID,
  input  logic [25:0] JumpTgt_ID,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [31:0] ImemData,
  output logic [31:0] FetchData_IF,
  output logic        FetchValid_IF,
  output logic [31:0] PcPlus4_IF
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] drop_addr, drop_addr_nxt;
  logic [31:0] skid_data, skid_data_nxt;
  logic [31:0] skid_pc4, skid_pc4_nxt;
  logic [31:0] fetch_data_nxt, pc_plus4_nxt;
  logic        fetch_valid_nxt;
  logic        ignore_ready;
  logic        ready_eff, jump_take, redirect;
  logic [31:0] redirect_tgt, pc_inc;

  // A response still in flight across reset belongs to the old request.
  assign ready_eff = ImemReady & ~ignore_ready;
  assign jump_take = Jump_ID & FetchValid_IF & ~AnyStall;
  assign redirect  = BranchTaken_EX | jump_take;
  assign pc_inc    = pc + 32'd4;

  always_comb begin
    redirect_tgt = {PcPlus4_IF[31:28], JumpTgt_ID, 2'b00};
    if (BranchTaken_EX) redirect_tgt = BranchTgt_EX;
  end

  assign ImemReq  = (state != HOLD);
  assign ImemAddr = (state == DROP) ? drop_addr : pc;

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    drop_addr_nxt   = drop_addr;
    skid_data_nxt   = skid_data;
    skid_pc4_nxt    = skid_pc4;
    fetch_data_nxt  = FetchData_IF;
    fetch_valid_nxt = FetchValid_IF;
    pc_plus4_nxt    = PcPlus4_IF;

    if (redirect) begin
      pc_nxt          = {redirect_tgt[31:2], 2'b00};
      fetch_valid_nxt = 1'b0;
      fetch_data_nxt  = NOP;
      skid_data_nxt   = NOP;
      skid_pc4_nxt    = '0;
      // An unanswered request must keep its address until memory responds.
      case (state)
        FETCH: begin
          if (!ready_eff) begin
            state_nxt     = DROP;
            drop_addr_nxt = pc;
          end
        end
        HOLD:    state_nxt = FETCH;
        default: state_nxt = state;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (ready_eff && !flush && !AnyStall) begin
            fetch_data_nxt  = ImemData;
            fetch_valid_nxt = 1'b1;
            pc_plus4_nxt    = pc_inc;
            pc_nxt          = pc_inc;
          end else if (ready_eff && !flush) begin
            skid_data_nxt = ImemData;
            skid_pc4_nxt  = pc_inc;
            state_nxt     = HOLD;
          end else if (!AnyStall) begin
            fetch_valid_nxt = 1'b0;
            fetch_data_nxt  = NOP;
          end
        end
        HOLD: begin
          if (!AnyStall && !flush) begin
            fetch_data_nxt  = skid_data;
            fetch_valid_nxt = 1'b1;
            pc_plus4_nxt    = skid_pc4;
            pc_nxt          = pc_inc;
            state_nxt       = FETCH;
          end
        end
        default: begin
          if (ready_eff) state_nxt = FETCH;
          if (!AnyStall) begin
            fetch_valid_nxt = 1'b0;
            fetch_data_nxt  = NOP;
          end
        end
      endcase

      if (flush) begin
        fetch_valid_nxt = 1'b0;
        fetch_data_nxt  = NOP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FETCH;
      pc            <= {RESET_PC[31:2], 2'b00};
      drop_addr     <= '0;
      skid_data     <= '0;
      skid_pc4      <= '0;
      FetchData_IF  <= NOP;
      FetchValid_IF <= 1'b0;
      PcPlus4_IF    <= '0;
      ignore_ready  <= 1'b1;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      drop_addr     <= drop_addr_nxt;
      skid_data     <= skid_data_nxt;
      skid_pc4      <= skid_pc4_nxt;
      FetchData_IF  <= fetch_data_nxt;
      FetchValid_IF <= fetch_valid_nxt;
      PcPlus4_IF    <= pc_plus4_nxt;
      ignore_ready  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run scored against an in-order instruction-stream model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        AnyStall;
  logic        flush;
  logic        BranchTaken_EX;
  logic [31:0] BranchTgt_EX;
  logic        Jump_ID;
  logic [25:0] JumpTgt_ID;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReady;
  logic [31:0] ImemData;
  logic [31:0] FetchData_IF;
  logic        FetchValid_IF;
  logic [31:0] PcPlus4_IF;

  logic [31:0] data_key = 32'h0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Memory image: every word is its own address scrambled by data_key.
  assign ImemData = ImemAddr ^ data_key;

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .AnyStall(AnyStall), .flush(flush),
    .BranchTaken_EX(BranchTaken_EX), .BranchTgt_EX(BranchTgt_EX),
    .Jump_ID(Jump_ID), .JumpTgt_ID(JumpTgt_ID),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemReady(ImemReady), .ImemData(ImemData),
    .FetchData_IF(FetchData_IF), .FetchValid_IF(FetchValid_IF), .PcPlus4_IF(PcPlus4_IF)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ data_key;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    AnyStall = 1'b0; flush = 1'b0; BranchTaken_EX = 1'b0; BranchTgt_EX = '0;
    Jump_ID = 1'b0; JumpTgt_ID = '0; ImemReady = 1'b0;
  endtask

  // Leaves the DUT out of reset with the request to address 0 pending.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    data_key  = 32'h0;
    ImemReady = 1'b1;
    reset     = 1'b1;
    tick(); tick();
    checks++; if (FetchValid_IF !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid got=%b exp=0", FetchValid_IF); end
    checks++; if (FetchData_IF !== 32'h0) begin failures++; $display("[TB] FAIL rst_data got=%h exp=0", FetchData_IF); end
    checks++; if (PcPlus4_IF !== 32'h0) begin failures++; $display("[TB] FAIL rst_pc4 got=%h exp=0", PcPlus4_IF); end
    checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin failures++; $display("[TB] FAIL rst_req got=%b/%h exp=1/0", ImemReq, ImemAddr); end
    reset = 1'b0;
    tick();
    checks++; if (FetchValid_IF !== 1'b0 || ImemAddr !== 32'h0) begin failures++; $display("[TB] FAIL rst_late_ready got=%b/%h exp=0/0", FetchValid_IF, ImemAddr); end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (ImemAddr !== 32'(4*(k+1)) || FetchData_IF !== 32'(4*k) || FetchValid_IF !== 1'b1 || PcPlus4_IF !== 32'(4*(k+1))) begin
        failures++;
        $display("[TB] FAIL seq_%0d got addr=%h data=%h v=%b pc4=%h exp addr=%h data=%h v=1 pc4=%h",
                 k, ImemAddr, FetchData_IF, FetchValid_IF, PcPlus4_IF, 32'(4*(k+1)), 32'(4*k), 32'(4*(k+1)));
      end
    end
  endtask

  task automatic test_ready_delay();
    data_key = 32'hA5A5_0000;
    do_reset();
    ImemReady = 1'b1;
    tick(); tick();
    ImemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ImemAddr !== 32'h8 || ImemReq !== 1'b1 || FetchValid_IF !== 1'b0) begin
        failures++;
        $display("[TB] FAIL wait_%0d got addr=%h req=%b v=%b exp addr=8 req=1 v=0", i, ImemAddr, ImemReq, FetchValid_IF);
      end
    end
    ImemReady = 1'b1;
    tick();
    checks++; if (FetchValid_IF !== 1'b1 || FetchData_IF !== mem_word(32'h8) || ImemAddr !== 32'hC) begin failures++; $display("[TB] FAIL wait_data got v=%b data=%h addr=%h exp v=1 data=%h addr=c", FetchValid_IF, FetchData_IF, ImemAddr, mem_word(32'h8)); end
    ImemReady = 1'b0;
    tick();
    checks++; if (FetchValid_IF !== 1'b0) begin failures++; $display("[TB] FAIL wait_once got v=%b exp 0", FetchValid_IF); end
  endtask

  task automatic test_stall_hold();
    data_key = 32'hA5A5_0000;
    do_reset();
    ImemReady = 1'b1;
    repeat (4) tick();
    AnyStall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (ImemReq !== 1'b0 || FetchData_IF !== mem_word(32'hC) || FetchValid_IF !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stall_%0d got req=%b data=%h v=%b exp req=0 data=%h v=1", i, ImemReq, FetchData_IF, FetchValid_IF, mem_word(32'hC));
      end
    end
    AnyStall = 1'b0;
    tick();
    checks++;
    if (FetchData_IF !== mem_word(32'h10) || PcPlus4_IF !== 32'h14 || ImemAddr !== 32'h14 || ImemReq !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_release got data=%h pc4=%h addr=%h req=%b exp data=%h pc4=14 addr=14 req=1", FetchData_IF, PcPlus4_IF, ImemAddr, ImemReq, mem_word(32'h10));
    end
  endtask

  task automatic test_branch_drop();
    logic saw_old = 1'b0;
    data_key = 32'hA5A5_0000;
    do_reset();
    ImemReady = 1'b1;
    repeat (8) tick();
    ImemReady = 1'b0; BranchTaken_EX = 1'b1; BranchTgt_EX = 32'h200;
    tick();
    BranchTaken_EX = 1'b0;
    checks++; if (ImemAddr !== 32'h20 || ImemReq !== 1'b1 || FetchValid_IF !== 1'b0) begin failures++; $display("[TB] FAIL drop_hold got addr=%h req=%b v=%b exp addr=20 req=1 v=0", ImemAddr, ImemReq, FetchValid_IF); end
    if (FetchData_IF === mem_word(32'h20)) saw_old = 1'b1;
    tick();
    checks++; if (ImemAddr !== 32'h20) begin failures++; $display("[TB] FAIL drop_stable got=%h exp=20", ImemAddr); end
    ImemReady = 1'b1;
    tick();
    if (FetchData_IF === mem_word(32'h20)) saw_old = 1'b1;
    checks++; if (ImemAddr !== 32'h200 || FetchValid_IF !== 1'b0) begin failures++; $display("[TB] FAIL drop_redirect got addr=%h v=%b exp addr=200 v=0", ImemAddr, FetchValid_IF); end
    tick();
    checks++; if (FetchData_IF !== mem_word(32'h200) || FetchValid_IF !== 1'b1) begin failures++; $display("[TB] FAIL drop_target got data=%h v=%b exp data=%h v=1", FetchData_IF, FetchValid_IF, mem_word(32'h200)); end
    checks++; if (saw_old !== 1'b0) begin failures++; $display("[TB] FAIL drop_discard got seen=%b exp 0", saw_old); end
  endtask

  task automatic test_jump();
    data_key = 32'hA5A5_0000;
    do_reset();
    ImemReady = 1'b1; BranchTaken_EX = 1'b1; BranchTgt_EX = 32'h1000_0004;
    tick();
    BranchTaken_EX = 1'b0;
    tick();
    checks++; if (PcPlus4_IF !== 32'h1000_0008 || FetchData_IF !== mem_word(32'h1000_0004)) begin failures++; $display("[TB] FAIL jmp_setup got pc4=%h data=%h exp pc4=10000008 data=%h", PcPlus4_IF, FetchData_IF, mem_word(32'h1000_0004)); end
    Jump_ID = 1'b1; JumpTgt_ID = 26'h40;
    tick();
    Jump_ID = 1'b0;
    checks++; if (ImemAddr !== 32'h1000_0100 || FetchValid_IF !== 1'b0) begin failures++; $display("[TB] FAIL jmp_target got addr=%h v=%b exp addr=10000100 v=0", ImemAddr, FetchValid_IF); end
    tick();
    Jump_ID = 1'b1; AnyStall = 1'b1; ImemReady = 1'b0;
    tick();
    checks++; if (ImemAddr !== 32'h1000_0104) begin failures++; $display("[TB] FAIL jmp_stalled got=%h exp=10000104", ImemAddr); end
    AnyStall = 1'b0; ImemReady = 1'b1; BranchTaken_EX = 1'b1; BranchTgt_EX = 32'h300;
    tick();
    Jump_ID = 1'b0; BranchTaken_EX = 1'b0;
    checks++; if (ImemAddr !== 32'h300) begin failures++; $display("[TB] FAIL jmp_vs_branch got=%h exp=300", ImemAddr); end
  endtask

  task automatic test_wrap_flush();
    data_key = 32'hA5A5_0000;
    do_reset();
    ImemReady = 1'b1; BranchTaken_EX = 1'b1; BranchTgt_EX = 32'hFFFF_FFFC;
    tick();
    BranchTaken_EX = 1'b0;
    tick();
    checks++; if (FetchData_IF !== mem_word(32'hFFFF_FFFC) || PcPlus4_IF !== 32'h0 || ImemAddr !== 32'h0) begin failures++; $display("[TB] FAIL wrap got data=%h pc4=%h addr=%h exp data=%h pc4=0 addr=0", FetchData_IF, PcPlus4_IF, ImemAddr, mem_word(32'hFFFF_FFFC)); end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (FetchValid_IF !== 1'b0 || FetchData_IF !== 32'h0 || ImemAddr !== 32'h4) begin failures++; $display("[TB] FAIL flush got v=%b data=%h addr=%h exp v=0 data=0 addr=4", FetchValid_IF, FetchData_IF, ImemAddr); end
    tick();
    checks++; if (FetchValid_IF !== 1'b1 || FetchData_IF !== mem_word(32'h4) || ImemAddr !== 32'h8) begin failures++; $display("[TB] FAIL refetch got v=%b data=%h addr=%h exp v=1 data=%h addr=8", FetchValid_IF, FetchData_IF, ImemAddr, mem_word(32'h4)); end
  endtask

  // Model: decode must see the program-order stream starting at the last
  // redirect; a flushed live word is skipped and never seen again.
  task automatic test_random();
    logic [31:0] exp_pc, held_addr;
    logic        pend;
    int          consumed = 0;
    data_key = 32'h3C3C_0F0F;
    do_reset();
    exp_pc = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      ImemReady      = ($urandom_range(0, 9) < 6);
      AnyStall       = ($urandom_range(0, 9) < 3);
      flush          = ($urandom_range(0, 19) == 0);
      BranchTaken_EX = ($urandom_range(0, 29) == 0);
      BranchTgt_EX   = $urandom;
      if (BranchTaken_EX) begin
        exp_pc = BranchTgt_EX & 32'hFFFF_FFFC;
      end else if (FetchValid_IF && flush) begin
        exp_pc = exp_pc + 32'd4;
      end else if (FetchValid_IF && !AnyStall) begin
        checks++;
        if (FetchData_IF !== mem_word(exp_pc) || PcPlus4_IF !== exp_pc + 32'd4) begin
          failures++;
          $display("[TB] FAIL rnd_stream cyc=%0d got data=%h pc4=%h exp data=%h pc4=%h", c, FetchData_IF, PcPlus4_IF, mem_word(exp_pc), exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      pend      = ImemReq && !ImemReady;
      held_addr = ImemAddr;
      tick();
      if (pend) begin
        checks++;
        if (ImemAddr !== held_addr) begin failures++; $display("[TB] FAIL rnd_addr_stable cyc=%0d got=%h exp=%h", c, ImemAddr, held_addr); end
      end
      if (ImemReq) begin
        checks++;
        if (ImemAddr[1:0] !== 2'b00) begin failures++; $display("[TB] FAIL rnd_align cyc=%0d got=%h", c, ImemAddr); end
      end
    end
    checks++; if (consumed < 200) begin failures++; $display("[TB] FAIL rnd_progress got=%0d exp>=200", consumed); end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_ready_delay();
    test_stall_hold();
    test_branch_drop();
    test_jump();
    test_wrap_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
